// File: rtl/m_program_sequencer.sv
// Program sequencer: registered PC with jump/call/return, halt-at-EOF and fault trapping.
// Optional return stack enabled by defining TERA_CALL_STACK_EN.
module m_program_sequencer #(
  parameter int unsigned           ADDR_WIDTH  = 8,
  parameter int unsigned           STACK_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] EOF_ADDR    = '1
) (
  input  logic                  w_clock,
  input  logic                  w_reset,
  input  logic                  w_stall,
  input  logic                  w_jump_flag,
  input  logic                  w_call_flag,
  input  logic                  w_return_flag,
  input  logic [ADDR_WIDTH-1:0] w_bus_target,
  output logic [ADDR_WIDTH-1:0] w_bus_pc,
  output logic [ADDR_WIDTH-1:0] w_bus_pc_plus1,
  output logic                  w_halted,
  output logic                  w_fault,
  output logic [4:0]            w_bus_stack_count
);

  // Bit 0 flags HALT and bit 1 flags FAULT so the status outputs come straight off the register.
  localparam logic [1:0] StRun   = 2'b00;
  localparam logic [1:0] StHalt  = 2'b01;
  localparam logic [1:0] StFault = 2'b10;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] pc_plus1;

  assign pc_plus1       = pc_q + 1'b1;
  assign w_bus_pc       = pc_q;
  assign w_bus_pc_plus1 = pc_plus1;
  assign w_halted       = state_q[0];
  assign w_fault        = state_q[1];

`ifdef TERA_CALL_STACK_EN
  localparam int unsigned IdxW     = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [4:0]  DepthCnt = 5'(STACK_DEPTH);

  logic [ADDR_WIDTH-1:0] stack_q [STACK_DEPTH];
  logic [4:0]            count_q, count_d;
  logic                  push_en;
  logic [IdxW-1:0]       push_idx;
  logic [IdxW-1:0]       pop_idx;

  assign push_idx          = IdxW'(count_q);
  assign pop_idx           = IdxW'(count_q - 5'd1);
  assign w_bus_stack_count = count_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    push_en = 1'b0;
    if (state_q == StRun) begin
      if (pc_q == EOF_ADDR) begin
        state_d = StHalt;
      end else if (!w_stall) begin
        if (w_return_flag) begin
          if (count_q == 5'd0) begin
            state_d = StFault;
          end else begin
            pc_d    = stack_q[pop_idx];
            count_d = count_q - 5'd1;
          end
        end else if (w_call_flag) begin
          if (count_q == DepthCnt) begin
            state_d = StFault;
          end else begin
            push_en = 1'b1;
            pc_d    = w_bus_target;
            count_d = count_q + 5'd1;
          end
        end else if (w_jump_flag) begin
          pc_d = w_bus_target;
        end else begin
          pc_d = pc_plus1;
        end
      end
    end
  end

  always_ff @(posedge w_clock or posedge w_reset) begin
    if (w_reset) begin
      state_q <= StRun;
      pc_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stack_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      if (push_en) begin
        stack_q[push_idx] <= pc_plus1;
      end
    end
  end
`else
  // Without a stack a call degenerates to a plain jump and returns are dropped.
  logic unused_return;
  assign unused_return     = w_return_flag;
  assign w_bus_stack_count = 5'd0;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (state_q == StRun) begin
      if (pc_q == EOF_ADDR) begin
        state_d = StHalt;
      end else if (!w_stall) begin
        if (w_call_flag || w_jump_flag) begin
          pc_d = w_bus_target;
        end else begin
          pc_d = pc_plus1;
        end
      end
    end
  end

  always_ff @(posedge w_clock or posedge w_reset) begin
    if (w_reset) begin
      state_q <= StRun;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end
`endif

endmodule

// File: tb/tb_m_program_sequencer.sv
// Directed self-checking bench for m_program_sequencer; expectations follow TERA_CALL_STACK_EN.
module tb_m_program_sequencer;

  logic       w_clock = 1'b0;
  logic       w_reset = 1'b1;
  logic       w_stall = 1'b0;
  logic       w_jump_flag = 1'b0;
  logic       w_call_flag = 1'b0;
  logic       w_return_flag = 1'b0;
  logic [7:0] w_bus_target = 8'h00;
  logic [7:0] w_bus_pc;
  logic [7:0] w_bus_pc_plus1;
  logic       w_halted;
  logic       w_fault;
  logic [4:0] w_bus_stack_count;

  int n_checks = 0;
  int n_fail   = 0;

  m_program_sequencer dut (
    .w_clock           (w_clock),
    .w_reset           (w_reset),
    .w_stall           (w_stall),
    .w_jump_flag       (w_jump_flag),
    .w_call_flag       (w_call_flag),
    .w_return_flag     (w_return_flag),
    .w_bus_target      (w_bus_target),
    .w_bus_pc          (w_bus_pc),
    .w_bus_pc_plus1    (w_bus_pc_plus1),
    .w_halted          (w_halted),
    .w_fault           (w_fault),
    .w_bus_stack_count (w_bus_stack_count)
  );

  always #5 w_clock = ~w_clock;

  task automatic advance(input int n);
    repeat (n) @(posedge w_clock);
    #1;
  endtask

  task automatic clear_inputs();
    w_stall = 1'b0; w_jump_flag = 1'b0; w_call_flag = 1'b0; w_return_flag = 1'b0;
    w_bus_target = 8'h00;
  endtask

  task automatic do_reset();
    clear_inputs();
    w_reset = 1'b1;
    advance(2);
    w_reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    w_reset = 1'b1;
    advance(2);
    n_checks++;
    if (w_bus_pc !== 8'h00 || w_halted !== 1'b0 || w_fault !== 1'b0 || w_bus_stack_count !== 5'd0)
    begin
      n_fail++;
      $display("FAIL reset_state: pc=%h halted=%b fault=%b cnt=%0d, want pc=00 0 0 0",
               w_bus_pc, w_halted, w_fault, w_bus_stack_count);
    end
    w_reset = 1'b0;
    advance(5);
    n_checks++;
    if (w_bus_pc !== 8'h05) begin
      n_fail++;
      $display("FAIL idle_count: pc=%h want 05", w_bus_pc);
    end
    // Asynchronous reset must act before the next clock edge.
    #2 w_reset = 1'b1;
    #1;
    n_checks++;
    if (w_bus_pc !== 8'h00) begin
      n_fail++;
      $display("FAIL async_reset: pc=%h want 00", w_bus_pc);
    end
    advance(1);
    w_reset = 1'b0;
  endtask

  task automatic test_call_return();
    do_reset();
    advance(3);
    n_checks++;
    if (w_bus_pc !== 8'h03 || w_bus_stack_count !== 5'd0) begin
      n_fail++;
      $display("FAIL cr_start: pc=%h cnt=%0d want 03 0", w_bus_pc, w_bus_stack_count);
    end
    w_call_flag = 1'b1; w_bus_target = 8'h40;
    advance(1);
    w_call_flag = 1'b0;
`ifdef TERA_CALL_STACK_EN
    n_checks++;
    if (w_bus_pc !== 8'h40 || w_bus_stack_count !== 5'd1) begin
      n_fail++;
      $display("FAIL cr_call: pc=%h cnt=%0d want 40 1", w_bus_pc, w_bus_stack_count);
    end
    advance(1);
    n_checks++;
    if (w_bus_pc !== 8'h41 || w_bus_stack_count !== 5'd1) begin
      n_fail++;
      $display("FAIL cr_step: pc=%h cnt=%0d want 41 1", w_bus_pc, w_bus_stack_count);
    end
    w_return_flag = 1'b1;
    advance(1);
    w_return_flag = 1'b0;
    n_checks++;
    if (w_bus_pc !== 8'h04 || w_bus_stack_count !== 5'd0) begin
      n_fail++;
      $display("FAIL cr_return: pc=%h cnt=%0d want 04 0", w_bus_pc, w_bus_stack_count);
    end
`else
    n_checks++;
    if (w_bus_pc !== 8'h40 || w_bus_stack_count !== 5'd0) begin
      n_fail++;
      $display("FAIL cr_call: pc=%h cnt=%0d want 40 0", w_bus_pc, w_bus_stack_count);
    end
    advance(1);
    w_return_flag = 1'b1;
    advance(1);
    w_return_flag = 1'b0;
    n_checks++;
    if (w_bus_pc !== 8'h42 || w_bus_stack_count !== 5'd0 || w_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL cr_return: pc=%h cnt=%0d fault=%b want 42 0 0",
               w_bus_pc, w_bus_stack_count, w_fault);
    end
`endif
  endtask

  task automatic test_overflow();
    logic [7:0] tgt [5];
    tgt[0] = 8'h10; tgt[1] = 8'h20; tgt[2] = 8'h30; tgt[3] = 8'h40; tgt[4] = 8'h50;
    do_reset();
    w_call_flag = 1'b1;
    for (int i = 0; i < 5; i++) begin
      w_bus_target = tgt[i];
      advance(1);
    end
    w_call_flag = 1'b0;
`ifdef TERA_CALL_STACK_EN
    n_checks++;
    if (w_bus_pc !== 8'h40 || w_fault !== 1'b1 || w_bus_stack_count !== 5'd4) begin
      n_fail++;
      $display("FAIL overflow: pc=%h fault=%b cnt=%0d want 40 1 4",
               w_bus_pc, w_fault, w_bus_stack_count);
    end
    w_jump_flag = 1'b1; w_return_flag = 1'b1; w_bus_target = 8'h60;
    advance(2);
    w_jump_flag = 1'b0; w_return_flag = 1'b0;
    n_checks++;
    if (w_bus_pc !== 8'h40 || w_fault !== 1'b1 || w_bus_stack_count !== 5'd4 || w_halted !== 1'b0)
    begin
      n_fail++;
      $display("FAIL fault_absorb: pc=%h fault=%b cnt=%0d halted=%b want 40 1 4 0",
               w_bus_pc, w_fault, w_bus_stack_count, w_halted);
    end
`else
    n_checks++;
    if (w_bus_pc !== 8'h50 || w_fault !== 1'b0 || w_bus_stack_count !== 5'd0) begin
      n_fail++;
      $display("FAIL overflow: pc=%h fault=%b cnt=%0d want 50 0 0",
               w_bus_pc, w_fault, w_bus_stack_count);
    end
`endif
  endtask

  task automatic test_return_empty();
    do_reset();
    advance(7);
    w_return_flag = 1'b1;
    advance(1);
    w_return_flag = 1'b0;
`ifdef TERA_CALL_STACK_EN
    n_checks++;
    if (w_bus_pc !== 8'h07 || w_fault !== 1'b1) begin
      n_fail++;
      $display("FAIL ret_empty: pc=%h fault=%b want 07 1", w_bus_pc, w_fault);
    end
`else
    n_checks++;
    if (w_bus_pc !== 8'h08 || w_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL ret_empty: pc=%h fault=%b want 08 0", w_bus_pc, w_fault);
    end
`endif
    #2 w_reset = 1'b1;
    #1;
    n_checks++;
    if (w_bus_pc !== 8'h00 || w_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL ret_empty_reset: pc=%h fault=%b want 00 0", w_bus_pc, w_fault);
    end
    advance(1);
    w_reset = 1'b0;
  endtask

  task automatic test_halt();
    do_reset();
    w_jump_flag = 1'b1; w_bus_target = 8'hFE;
    advance(1);
    w_jump_flag = 1'b0; w_stall = 1'b1;
    n_checks++;
    if (w_bus_pc !== 8'hFE || w_bus_pc_plus1 !== 8'hFF) begin
      n_fail++;
      $display("FAIL halt_jump: pc=%h pc1=%h want FE FF", w_bus_pc, w_bus_pc_plus1);
    end
    for (int i = 0; i < 3; i++) begin
      advance(1);
      n_checks++;
      if (w_bus_pc !== 8'hFE) begin
        n_fail++;
        $display("FAIL halt_stall%0d: pc=%h want FE", i, w_bus_pc);
      end
    end
    w_stall = 1'b0;
    advance(1);
    n_checks++;
    if (w_bus_pc !== 8'hFF || w_halted !== 1'b0 || w_bus_pc_plus1 !== 8'h00) begin
      n_fail++;
      $display("FAIL halt_eof: pc=%h halted=%b pc1=%h want FF 0 00",
               w_bus_pc, w_halted, w_bus_pc_plus1);
    end
    // Stall and a jump must not keep the sequencer out of HALT.
    w_stall = 1'b1; w_jump_flag = 1'b1; w_bus_target = 8'h10;
    advance(1);
    n_checks++;
    if (w_bus_pc !== 8'hFF || w_halted !== 1'b1 || w_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_enter: pc=%h halted=%b fault=%b want FF 1 0", w_bus_pc, w_halted, w_fault);
    end
    w_stall = 1'b0; w_call_flag = 1'b1;
    advance(2);
    clear_inputs();
    n_checks++;
    if (w_bus_pc !== 8'hFF || w_halted !== 1'b1 || w_bus_stack_count !== 5'd0) begin
      n_fail++;
      $display("FAIL halt_absorb: pc=%h halted=%b cnt=%0d want FF 1 0",
               w_bus_pc, w_halted, w_bus_stack_count);
    end
  endtask

  task automatic test_priority();
    do_reset();
    advance(2);
    w_call_flag = 1'b1; w_jump_flag = 1'b1; w_bus_target = 8'h10;
    advance(1);
    w_jump_flag = 1'b0;
`ifdef TERA_CALL_STACK_EN
    n_checks++;
    if (w_bus_pc !== 8'h10 || w_bus_stack_count !== 5'd1) begin
      n_fail++;
      $display("FAIL prio_call: pc=%h cnt=%0d want 10 1", w_bus_pc, w_bus_stack_count);
    end
    // Return beats a simultaneous call and pops the pushed 3.
    w_return_flag = 1'b1; w_bus_target = 8'h77;
    advance(1);
    n_checks++;
    if (w_bus_pc !== 8'h03 || w_bus_stack_count !== 5'd0) begin
      n_fail++;
      $display("FAIL prio_return: pc=%h cnt=%0d want 03 0", w_bus_pc, w_bus_stack_count);
    end
`else
    n_checks++;
    if (w_bus_pc !== 8'h10 || w_bus_stack_count !== 5'd0) begin
      n_fail++;
      $display("FAIL prio_call: pc=%h cnt=%0d want 10 0", w_bus_pc, w_bus_stack_count);
    end
    w_call_flag = 1'b0; w_return_flag = 1'b1;
    advance(1);
    n_checks++;
    if (w_bus_pc !== 8'h11) begin
      n_fail++;
      $display("FAIL prio_return: pc=%h want 11", w_bus_pc);
    end
`endif
    clear_inputs();
  endtask

  task automatic test_reset_mid_call();
    do_reset();
    advance(3);
    w_call_flag = 1'b1; w_bus_target = 8'h40;
    #2 w_reset = 1'b1;
    advance(1);
    n_checks++;
    if (w_bus_pc !== 8'h00 || w_bus_stack_count !== 5'd0) begin
      n_fail++;
      $display("FAIL midcall_reset: pc=%h cnt=%0d want 00 0", w_bus_pc, w_bus_stack_count);
    end
    w_call_flag = 1'b0;
    w_reset = 1'b0;
    advance(1);
    n_checks++;
    if (w_bus_pc !== 8'h01 || w_bus_stack_count !== 5'd0) begin
      n_fail++;
      $display("FAIL midcall_resume: pc=%h cnt=%0d want 01 0", w_bus_pc, w_bus_stack_count);
    end
  endtask

  initial begin
    test_reset();
    test_call_return();
    test_overflow();
    test_return_empty();
    test_halt();
    test_priority();
    test_reset_mid_call();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/m_program_sequencer.md
M_PROGRAM_SEQUENCER -- requirements
Module: m_program_sequencer

Interface
REQ-001 The parameter ADDR_WIDTH SHALL default to 8 and set the instruction address width.
REQ-002 The parameter STACK_DEPTH SHALL default to 4 and set the number of return-stack entries, with a legal range of 2..16.
REQ-003 The parameter EOF_ADDR SHALL default to all ones at ADDR_WIDTH and set the halt address.
REQ-004 Port w_clock SHALL be an input, 1 bit wide, and is the single clock; all state updates occur on its rising edge.
REQ-005 Port w_reset SHALL be an input, 1 bit wide, and is the reset; it is asynchronous and active-high.
REQ-006 Port w_stall SHALL be an input, 1 bit wide, and holds all state for the cycle.
REQ-007 Port w_jump_flag SHALL be an input, 1 bit wide, and requests a load of PC from w_bus_target.
REQ-008 Port w_call_flag SHALL be an input, 1 bit wide, and requests a push of PC+1 followed by a jump to w_bus_target.
REQ-009 Port w_return_flag SHALL be an input, 1 bit wide, and requests a pop of the stack top into PC.
REQ-010 Port w_bus_target SHALL be an input, ADDR_WIDTH bits wide, and carries the jump or call destination (ALU output).
REQ-011 Port w_bus_pc SHALL be an output, ADDR_WIDTH bits wide, and carries the registered program counter (instruction memory address).
REQ-012 Port w_bus_pc_plus1 SHALL be an output, ADDR_WIDTH bits wide, and is combinational PC+1 mod 2^ADDR_WIDTH, used for the store-PC write-back.
REQ-013 Port w_halted SHALL be an output, 1 bit wide, and is high in the HALT state.
REQ-014 Port w_fault SHALL be an output, 1 bit wide, and is high in the FAULT state.
REQ-015 Port w_bus_stack_count SHALL be an output, 5 bits wide, and carries the number of valid stack entries.

Function
REQ-016 The FSM SHALL have three states: RUN, HALT, and FAULT; reset enters RUN.
REQ-017 In RUN with w_stall=1, the block SHALL hold PC, the stack, and the state.
REQ-018 In RUN without stall, the next PC SHALL be selected by the priority return > call > jump > PC+1; lower-priority flags asserted in the same cycle are ignored.
REQ-019 PC increment SHALL wrap from 2^ADDR_WIDTH-1 to 0 when EOF_ADDR differs from that value.
REQ-020 A call with count<STACK_DEPTH SHALL push PC+1, increment the count, and set PC=w_bus_target, all in one edge.
REQ-021 A call with count==STACK_DEPTH (full) SHALL leave PC and the stack unchanged and enter FAULT.
REQ-022 A return with count>0 SHALL set PC to the top entry and decrement the count in one edge.
REQ-023 A return with count==0 (empty) SHALL leave PC unchanged and enter FAULT.
REQ-024 When the registered PC equals EOF_ADDR in RUN, the next edge SHALL enter HALT regardless of flags or stall, and PC SHALL hold at EOF_ADDR.
REQ-025 HALT and FAULT SHALL be absorbing: PC, stack, and count freeze, all flags are ignored, and only reset exits.
REQ-026 A jump or call whose target equals EOF_ADDR SHALL be taken normally; HALT follows on the next edge per REQ-024.
REQ-027 Outputs w_bus_pc, w_halted, w_fault, and w_bus_stack_count SHALL be registered, with zero-cycle latency from state to output.

Reset
REQ-028 Assertion of w_reset SHALL immediately force PC=0, count=0, state=RUN, w_halted=0, and w_fault=0, independent of w_clock.
REQ-029 Stack entry contents SHALL be cleared to 0 on reset.
REQ-030 Reset asserted mid-call or mid-return SHALL discard the operation; the first active edge after deassertion SHALL behave as a RUN cycle from PC=0.

Configuration
REQ-031 Macro TERA_CALL_STACK_EN defined SHALL build the stack and call/return logic per REQ-020..023.
REQ-032 Macro TERA_CALL_STACK_EN undefined SHALL omit the stack, treat w_call_flag as w_jump_flag, ignore w_return_flag, and tie w_bus_stack_count to 0; FAULT is unreachable in this build.

Verification
REQ-033 Reset for 2 cycles, release, then 5 idle edges -> w_bus_pc=5.
REQ-034 At PC=3, call target 8'h40; at PC=8'h41, return -> PC sequence 3,8'h40,8'h41,4; count sequence 0,1,1,0.
REQ-035 With STACK_DEPTH=4, perform 5 nested calls -> the 5th leaves PC unchanged, w_fault=1, count=4; subsequent flags have no effect.
REQ-036 Return with empty stack at PC=7 -> w_fault=1, PC stays 7; then pulse reset -> PC=0, w_fault=0.
REQ-037 Jump to 8'hFE with stall held 3 cycles, then release -> PC 8'hFE for 4 cycles, then 8'hFF, then w_halted=1 with PC stuck at 8'hFF.
REQ-038 Call and jump asserted together at PC=2 with target 8'h10 -> call wins: PC=8'h10, stack top=3; repeat with the macro undefined -> PC=8'h10, count=0.
